pio_cmd_master: RTL and testbench
=================================

PIO_CMD_MASTER -- requirements
Module: pio_cmd_master

Interface
REQ-001 SHALL have parameter DATA_W, 28, width of the controlled PIO port; readback bits above DATA_W are ignored.
REQ-002 SHALL have parameter READ_LATENCY, 1, cycles from address phase to valid avm_readdata; legal range 1..4.
REQ-003 SHALL have parameter POLL_TIMEOUT, 1024, maximum read attempts per WAIT command.
REQ-004 SHALL have clk, input, 1, clock; all logic on its rising edge.
REQ-005 SHALL have reset_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have cmd_valid/cmd_ready, input/output, 1/1, command handshake.
REQ-007 SHALL have cmd_op, input, 3, opcode: 0 WRITE, 1 READ, 2 SET, 3 CLR, 4 TOG, 5 WAIT, 6-7 illegal.
REQ-008 SHALL have cmd_reg, input, 2, target register address (0 data, 1 direction).
REQ-009 SHALL have cmd_data and cmd_mask, input, 32 each, operand and WAIT compare mask.
REQ-010 SHALL have rsp_valid/rsp_ready, output/input, 1/1, response handshake.
REQ-011 SHALL have rsp_data, output, 32, and rsp_err, output, 1: result value and error flag.
REQ-012 SHALL have avm_address (output, 2), avm_chipselect (output, 1), avm_write_n (output, 1), avm_writedata (output, 32), and avm_readdata (input, 32), forming the Avalon-MM master port.

Function
REQ-013 SHALL use FSM states IDLE, RD, RLAT, WR, POLLGAP, RSP; cmd_ready=1 only in IDLE.
REQ-014 SHALL accept a command at cmd_valid&cmd_ready edge T and register op/reg/data/mask.
REQ-015 SHALL, for WRITE: WR at T+1 (chipselect=1, write_n=0, address=reg, writedata=data), then RSP at T+2 with rsp_data=data.
REQ-016 SHALL, for READ: RD at T+1 (chipselect=1, write_n=1, address=reg); RLAT READ_LATENCY cycles; capture readdata on the last RLAT cycle; RSP next (T+2+READ_LATENCY).
REQ-017 SHALL, for SET/CLR/TOG: read as REQ-016, then WR with old|data, old&~data, or old^data respectively; RSP carries the written value.
REQ-018 SHALL zero-extend all captured and written values above bit DATA_W-1.
REQ-019 SHALL, for an illegal op, go IDLE->RSP directly with rsp_err=1, rsp_data=0, and no bus cycle.
REQ-020 SHALL hold rsp_valid=1 and rsp_data/rsp_err stable in RSP until rsp_ready=1; return to IDLE the cycle after.
REQ-021 SHALL drive avm_chipselect=0, avm_write_n=1, and avm_address/avm_writedata unchanged outside RD/WR.
REQ-022 SHALL assert exactly one write strobe per WRITE/SET/CLR/TOG command.

Reset
REQ-023 SHALL, with reset_n=0: state IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0, poll counter=0.
REQ-024 SHALL abort any in-flight command on reset mid-operation, with no write strobe and no response issued.

Configuration
REQ-025 SHALL implement WAIT only when PIO_CMD_MASTER_POLL_EN is defined: repeat RD/RLAT, POLLGAP one idle cycle between reads, until (rd&mask)==(data&mask) -> RSP rsp_err=0, or POLL_TIMEOUT reads done -> RSP rsp_err=1; rsp_data = last read.
REQ-026 SHALL, without PIO_CMD_MASTER_POLL_EN, treat op 5 as illegal (REQ-019), omitting the poll counter and POLLGAP.

Structure
REQ-027 SHALL place the opcode enum, FSM state enum, and register address constants (REG_DATA=0, REG_DIR=1) in shared package pio_cmd_pkg.
REQ-028 SHALL be a single flat module; no sub-module.

Verification
REQ-029 SHALL verify: WRITE reg0 data=0x0000_00A5 -> one strobe at T+1 with writedata 0xA5; rsp at T+2 with data 0xA5, err 0.
REQ-030 SHALL verify: READ reg1 with slave dir=0x0F0, READ_LATENCY=1 -> rsp_valid at T+3 with rsp_data 0x0F0.
REQ-031 SHALL verify: data=0x0FF then SET 0x100, CLR 0x00F, TOG 0x0FFFFFFF -> written values 0x1FF, 0x1F0, 0x0FFFFE0F.
REQ-032 SHALL verify: rsp_ready held low 5 cycles -> rsp stable, cmd_ready=0, no bus activity; op 7 -> err=1 with no strobe.
REQ-033 SHALL verify, with POLL_EN: WAIT mask 0x1, data 0x1, pin driven high after 3 reads -> err=0; pin never high, POLL_TIMEOUT=8 -> exactly 8 reads, err=1.
REQ-034 SHALL verify: reset_n low during RLAT of SET -> no write strobe; all outputs at REQ-023 values; next command executes normally.

Source files
------------

// File: rtl/pio_cmd_pkg.sv
// Shared definitions for the PIO command master: command opcodes, FSM
// states and the register map of the controlled PIO peripheral.
package pio_cmd_pkg;

   typedef enum logic [2:0] {
      OP_WRITE = 3'd0,
      OP_READ  = 3'd1,
      OP_SET   = 3'd2,
      OP_CLR   = 3'd3,
      OP_TOG   = 3'd4,
      OP_WAIT  = 3'd5
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_RLAT,
      ST_WR,
      ST_POLLGAP,
      ST_RSP
   } state_t;

   localparam logic [1:0] REG_DATA = 2'd0;
   localparam logic [1:0] REG_DIR  = 2'd1;

endpackage

// File: rtl/pio_cmd_master.sv
// PIO command master: accepts register commands (WRITE, READ, SET, CLR, TOG
// and optionally WAIT) and turns them into Avalon-MM cycles on a PIO core,
// returning one response per command.
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_op, cmd_reg                opcode, target register
//   cmd_data, cmd_mask             operand, WAIT compare mask
//   rsp_valid/rsp_ready            response handshake
//   rsp_data, rsp_err              result value, error flag
//   avm_*                          Avalon-MM master port
//
// Configuration macro: PIO_CMD_MASTER_POLL_EN enables the WAIT command
// (poll until masked readback matches); without it opcode 5 is illegal.
module pio_cmd_master
   import pio_cmd_pkg::*;
#(
   parameter int DATA_W       = 28,
   parameter int READ_LATENCY = 1,
   parameter int POLL_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [1:0]  cmd_reg,
   input  logic [31:0] cmd_data,
   input  logic [31:0] cmd_mask,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic [1:0]  avm_address,
   output logic        avm_chipselect,
   output logic        avm_write_n,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata
);

   // Bits of the PIO port that actually exist; everything above is forced to 0.
   localparam logic [31:0] DATA_MASK = (DATA_W >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'h1 << DATA_W) - 32'h1);

   state_t      state, next_state;
   op_t         op_q;
   logic [31:0] data_q;
   logic [2:0]  lat_cnt;
   logic        accept;
   logic        lat_last;
   logic [31:0] rd_value;
   logic [31:0] mod_value;

`ifdef PIO_CMD_MASTER_POLL_EN
   localparam int PW = $clog2(POLL_TIMEOUT + 1);
   logic [31:0]   mask_q;
   logic [PW-1:0] poll_cnt;
   logic          poll_match;
   logic          poll_last;

   assign poll_match = ((rd_value & mask_q) == (data_q & mask_q));
   assign poll_last  = (poll_cnt == PW'(POLL_TIMEOUT - 1));
`else
   logic unused_mask;
   assign unused_mask = ^cmd_mask;
`endif

   function automatic logic op_legal(input logic [2:0] op);
`ifdef PIO_CMD_MASTER_POLL_EN
      return (op <= 3'd5);
`else
      return (op <= 3'd4);
`endif
   endfunction

   assign accept         = cmd_valid & cmd_ready;
   assign cmd_ready      = (state == ST_IDLE);
   assign rsp_valid      = (state == ST_RSP);
   assign avm_chipselect = (state == ST_RD) || (state == ST_WR);
   assign avm_write_n    = (state != ST_WR);
   assign rd_value       = avm_readdata & DATA_MASK;
   assign lat_last       = (lat_cnt == 3'(READ_LATENCY - 1));

   // Read-modify-write result for SET/CLR/TOG, computed from the word being
   // captured at the end of the read latency.
   always_comb begin
      mod_value = rd_value;
      case (op_q)
         OP_SET:  mod_value = rd_value | data_q;
         OP_CLR:  mod_value = rd_value & ~data_q;
         OP_TOG:  mod_value = rd_value ^ data_q;
         default: mod_value = rd_value;
      endcase
      mod_value = mod_value & DATA_MASK;
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= next_state;
   end

   // Next-state logic. Illegal opcodes skip the bus entirely.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (!op_legal(cmd_op))            next_state = ST_RSP;
               else if (cmd_op == 3'(OP_WRITE))  next_state = ST_WR;
               else                              next_state = ST_RD;
            end
         end
         ST_RD: next_state = ST_RLAT;
         ST_RLAT: begin
            if (lat_last) begin
               case (op_q)
                  OP_SET, OP_CLR, OP_TOG: next_state = ST_WR;
`ifdef PIO_CMD_MASTER_POLL_EN
                  OP_WAIT: next_state = (poll_match || poll_last) ? ST_RSP : ST_POLLGAP;
`endif
                  default: next_state = ST_RSP;
               endcase
            end
         end
         ST_WR: next_state = ST_RSP;
`ifdef PIO_CMD_MASTER_POLL_EN
         ST_POLLGAP: next_state = ST_RD;
`endif
         ST_RSP: if (rsp_ready) next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Command registers, bus address/data and response registers. Address and
   // write data only change on command accept or at read capture, so they
   // hold their value outside the bus states.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q          <= OP_WRITE;
         data_q        <= '0;
         lat_cnt       <= '0;
         rsp_data      <= '0;
         rsp_err       <= 1'b0;
         avm_address   <= '0;
         avm_writedata <= '0;
`ifdef PIO_CMD_MASTER_POLL_EN
         mask_q        <= '0;
         poll_cnt      <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q   <= op_t'(cmd_op);
                  data_q <= cmd_data;
`ifdef PIO_CMD_MASTER_POLL_EN
                  mask_q   <= cmd_mask;
                  poll_cnt <= '0;
`endif
                  if (op_legal(cmd_op)) begin
                     avm_address <= cmd_reg;
                     rsp_err     <= 1'b0;
                     if (cmd_op == 3'(OP_WRITE)) begin
                        avm_writedata <= cmd_data & DATA_MASK;
                        rsp_data      <= cmd_data & DATA_MASK;
                     end
                  end else begin
                     rsp_data <= '0;
                     rsp_err  <= 1'b1;
                  end
               end
            end
            ST_RD: lat_cnt <= '0;
            ST_RLAT: begin
               lat_cnt <= lat_cnt + 3'd1;
               if (lat_last) begin
                  case (op_q)
                     OP_SET, OP_CLR, OP_TOG: begin
                        avm_writedata <= mod_value;
                        rsp_data      <= mod_value;
                     end
`ifdef PIO_CMD_MASTER_POLL_EN
                     OP_WAIT: begin
                        rsp_data <= rd_value;
                        rsp_err  <= !poll_match;
                        poll_cnt <= poll_cnt + PW'(1);
                     end
`endif
                     default: rsp_data <= rd_value;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pio_cmd_master.sv
// Self-checking bench for pio_cmd_master: directed command sequence against
// a small Avalon-MM PIO slave model with hand-computed expectations.
// Readback always carries junk in bits 31:28 that the master must strip.
// Build with PIO_CMD_MASTER_POLL_EN to exercise WAIT.
module tb_pio_cmd_master;
   import pio_cmd_pkg::*;

   localparam int DATA_W       = 28;
   localparam int READ_LATENCY = 1;
   localparam int POLL_TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = 3'd0;
   logic [1:0]  cmd_reg = 2'd0;
   logic [31:0] cmd_data = 32'h0;
   logic [31:0] cmd_mask = 32'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic [1:0]  avm_address;
   logic        avm_chipselect;
   logic        avm_write_n;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata = 32'h0;

   int errors = 0;
   int checks = 0;

   int cyc = 0;
   int accept_cyc = 0;
   int write_cyc = 0;
   int write_count = 0;
   int read_count = 0;
   int bus_count = 0;
   logic [31:0] last_wdata = 32'h0;
   logic [1:0]  last_waddr = 2'd0;
   logic [31:0] slave_regs [4] = '{default: 32'h0};
   logic        pin_mode = 1'b0;
   int          read_base = 0;

   pio_cmd_master #(
      .DATA_W(DATA_W),
      .READ_LATENCY(READ_LATENCY),
      .POLL_TIMEOUT(POLL_TIMEOUT)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op(cmd_op),
      .cmd_reg(cmd_reg),
      .cmd_data(cmd_data),
      .cmd_mask(cmd_mask),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data(rsp_data),
      .rsp_err(rsp_err),
      .avm_address(avm_address),
      .avm_chipselect(avm_chipselect),
      .avm_write_n(avm_write_n),
      .avm_writedata(avm_writedata),
      .avm_readdata(avm_readdata)
   );

   always #5 clk = ~clk;

   // PIO slave model with one cycle of read latency plus event logging.
   // In pin_mode, bit 0 reads high from the fourth read onward.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cmd_valid && cmd_ready) accept_cyc <= cyc;
      if (avm_chipselect) bus_count <= bus_count + 1;
      if (avm_chipselect && !avm_write_n) begin
         slave_regs[avm_address] <= avm_writedata;
         write_count <= write_count + 1;
         last_wdata  <= avm_writedata;
         last_waddr  <= avm_address;
         write_cyc   <= cyc;
      end
      if (avm_chipselect && avm_write_n) begin
         read_count   <= read_count + 1;
         avm_readdata <= slave_regs[avm_address] | 32'hF000_0000 |
                         {31'h0, (pin_mode && ((read_count - read_base) >= 3))};
      end
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic issue_cmd(input logic [2:0] op, input logic [1:0] rg,
                            input logic [31:0] data, input logic [31:0] mask);
      @(negedge clk);
      check_output("cmd_ready_idle", cmd_ready, 32'h1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_reg   = rg;
      cmd_data  = data;
      cmd_mask  = mask;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         lat++;
         if (rsp_valid) break;
      end
      check_output("rsp_valid_seen", rsp_valid, 32'h1);
   endtask

   task automatic ack_rsp();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   task automatic apply_stimulus(input logic [2:0] op, input logic [1:0] rg,
                                 input logic [31:0] data, input logic [31:0] mask,
                                 output int lat, output logic [31:0] rdata,
                                 output logic rerr);
      issue_cmd(op, rg, data, mask);
      wait_rsp(lat);
      rdata = rsp_data;
      rerr  = rsp_err;
      ack_rsp();
   endtask

   task automatic check_reset_outputs();
      check_output("rst_cmd_ready", cmd_ready, 32'h1);
      check_output("rst_rsp_valid", rsp_valid, 32'h0);
      check_output("rst_rsp_data", rsp_data, 32'h0);
      check_output("rst_rsp_err", rsp_err, 32'h0);
      check_output("rst_chipselect", avm_chipselect, 32'h0);
      check_output("rst_write_n", avm_write_n, 32'h1);
      check_output("rst_address", avm_address, 32'h0);
      check_output("rst_writedata", avm_writedata, 32'h0);
   endtask

   initial begin
      int          lat;
      logic [31:0] rdata;
      logic        rerr;
      int          wc_base;
      int          rc_base;
      int          bus_base;

      // Power-on reset.
      repeat (3) @(negedge clk);
      check_reset_outputs();
      reset_n = 1'b1;

      // WRITE reg0 0xA5: strobe one edge after accept, response next cycle.
      wc_base = write_count;
      apply_stimulus(3'd0, REG_DATA, 32'h0000_00A5, 32'h0, lat, rdata, rerr);
      check_output("wr_lat", lat, 32'd2);
      check_output("wr_rsp_data", rdata, 32'h0000_00A5);
      check_output("wr_rsp_err", rerr, 32'h0);
      check_output("wr_count", write_count - wc_base, 32'd1);
      check_output("wr_addr", last_waddr, 32'h0);
      check_output("wr_wdata", last_wdata, 32'h0000_00A5);
      check_output("wr_offset", write_cyc - accept_cyc, 32'd1);

      // Direction register 0x0F0, then READ it back (junk upper bits stripped).
      apply_stimulus(3'd0, REG_DIR, 32'h0000_00F0, 32'h0, lat, rdata, rerr);
      rc_base = read_count;
      apply_stimulus(3'd1, REG_DIR, 32'h0, 32'h0, lat, rdata, rerr);
      check_output("rd_lat", lat, 32'd3);
      check_output("rd_rsp_data", rdata, 32'h0000_00F0);
      check_output("rd_rsp_err", rerr, 32'h0);
      check_output("rd_count", read_count - rc_base, 32'd1);

      // Read-modify-write sequence on the data register.
      apply_stimulus(3'd0, REG_DATA, 32'h0000_00FF, 32'h0, lat, rdata, rerr);
      wc_base = write_count;
      apply_stimulus(3'd2, REG_DATA, 32'h0000_0100, 32'h0, lat, rdata, rerr);
      check_output("set_lat", lat, 32'd4);
      check_output("set_rsp", rdata, 32'h0000_01FF);
      check_output("set_wdata", last_wdata, 32'h0000_01FF);
      check_output("set_offset", write_cyc - accept_cyc, 32'd3);
      apply_stimulus(3'd3, REG_DATA, 32'h0000_000F, 32'h0, lat, rdata, rerr);
      check_output("clr_rsp", rdata, 32'h0000_01F0);
      check_output("clr_wdata", last_wdata, 32'h0000_01F0);
      apply_stimulus(3'd4, REG_DATA, 32'h0FFF_FFFF, 32'h0, lat, rdata, rerr);
      check_output("tog_rsp", rdata, 32'h0FFF_FE0F);
      check_output("tog_wdata", last_wdata, 32'h0FFF_FE0F);
      check_output("rmw_write_count", write_count - wc_base, 32'd3);

      // Response back-pressure: everything frozen while rsp_ready is low.
      issue_cmd(3'd1, REG_DATA, 32'h0, 32'h0);
      wait_rsp(lat);
      bus_base = bus_count;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_output("hold_rsp_valid", rsp_valid, 32'h1);
         check_output("hold_rsp_data", rsp_data, 32'h0FFF_FE0F);
         check_output("hold_rsp_err", rsp_err, 32'h0);
         check_output("hold_cmd_ready", cmd_ready, 32'h0);
         check_output("hold_chipselect", avm_chipselect, 32'h0);
      end
      check_output("hold_bus_idle", bus_count - bus_base, 32'd0);
      ack_rsp();
      @(negedge clk);
      check_output("hold_release_ready", cmd_ready, 32'h1);

      // Reset during the read-latency cycle of a SET: aborted, no strobe.
      wc_base = write_count;
      issue_cmd(3'd2, REG_DATA, 32'h0000_0001, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_reset_outputs();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check_output("abort_rsp_valid", rsp_valid, 32'h0);
      check_output("abort_no_write", write_count - wc_base, 32'd0);
      check_output("abort_reg_kept", slave_regs[0], 32'h0FFF_FE0F);
      apply_stimulus(3'd0, REG_DATA, 32'h0000_005A, 32'h0, lat, rdata, rerr);
      check_output("post_rst_lat", lat, 32'd2);
      check_output("post_rst_rsp", rdata, 32'h0000_005A);
      check_output("post_rst_wdata", last_wdata, 32'h0000_005A);

      // Illegal opcode 7: immediate error response, no bus cycle.
      bus_base = bus_count;
      apply_stimulus(3'd7, REG_DATA, 32'h1234_5678, 32'h0, lat, rdata, rerr);
      check_output("ill_lat", lat, 32'd1);
      check_output("ill_rsp_data", rdata, 32'h0);
      check_output("ill_rsp_err", rerr, 32'h1);
      check_output("ill_no_bus", bus_count - bus_base, 32'd0);

`ifdef PIO_CMD_MASTER_POLL_EN
      // WAIT on bit 0; the pin rises on the fourth read.
      apply_stimulus(3'd0, REG_DATA, 32'h0, 32'h0, lat, rdata, rerr);
      read_base = read_count;
      pin_mode  = 1'b1;
      apply_stimulus(3'd5, REG_DATA, 32'h1, 32'h1, lat, rdata, rerr);
      check_output("wait_ok_reads", read_count - read_base, 32'd4);
      check_output("wait_ok_lat", lat, 32'd12);
      check_output("wait_ok_err", rerr, 32'h0);
      check_output("wait_ok_data", rdata, 32'h1);

      // WAIT where the pin never rises: gives up after POLL_TIMEOUT reads.
      pin_mode = 1'b0;
      rc_base  = read_count;
      apply_stimulus(3'd5, REG_DATA, 32'h1, 32'h1, lat, rdata, rerr);
      check_output("wait_to_reads", read_count - rc_base, 32'd8);
      check_output("wait_to_lat", lat, 32'd24);
      check_output("wait_to_err", rerr, 32'h1);
      check_output("wait_to_data", rdata, 32'h0);
`else
      // Without polling support opcode 5 is just another illegal opcode.
      bus_base = bus_count;
      apply_stimulus(3'd5, REG_DATA, 32'h1, 32'h1, lat, rdata, rerr);
      check_output("op5_lat", lat, 32'd1);
      check_output("op5_err", rerr, 32'h1);
      check_output("op5_data", rdata, 32'h0);
      check_output("op5_no_bus", bus_count - bus_base, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
